// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state encoding,
// jump-select encodings, default reset PC and the branch-offset helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    // Encoding 2'b11 is deliberately absent: it behaves like JSEL_SEQ.
    localparam logic [1:0] JSEL_SEQ = 2'b00;
    localparam logic [1:0] JSEL_J   = 2'b01;
    localparam logic [1:0] JSEL_JR  = 2'b10;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational redirect target for the held instruction:
// jr beats j/jal, which beats a taken branch, which beats the sequential PC.
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [1:0]  jump_sel_i,
    input  logic        branch_taken_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_plus4_i,
    output logic [31:0] next_pc_o
);

    always_comb begin
        next_pc_o = pc_plus4_i;
        if (jump_sel_i == JSEL_JR) begin
            next_pc_o = rs_data_i;
        end else if (jump_sel_i == JSEL_J) begin
            next_pc_o = {pc_plus4_i[31:28], instr_i[25:0], 2'b00};
        end else if (branch_taken_i) begin
            next_pc_o = pc_plus4_i + branch_offset(instr_i[15:0]);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch FSM (IDLE/FETCH/HOLD/FAULT) with registered outputs.
// Build option FETCH_ALIGN_CHK_EN: trap misaligned redirect targets in FAULT instead of masking them.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic [1:0]  jump_sel_i,
    input  logic        branch_taken_i,
    input  logic [31:0] rs_data_i,
    output logic        fault_o,
    output logic [1:0]  dbg_state_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_hold_q, pc_hold_d;
    logic [31:0]  pc_plus4_q, pc_plus4_d;
    logic         req_q, req_d;
    logic         valid_q, valid_d;
    logic [31:0]  next_pc;
    logic         handshake;

    next_pc_calc u_next_pc_calc (
        .jump_sel_i     (jump_sel_i),
        .branch_taken_i (branch_taken_i),
        .rs_data_i      (rs_data_i),
        .instr_i        (instr_q),
        .pc_plus4_i     (pc_plus4_q),
        .next_pc_o      (next_pc)
    );

    // Decoder handshake: instr_valid_o rises only in HOLD and stays high with
    // instr_o/pc_o/pc_plus4_o frozen; the transfer happens in the one cycle where
    // instr_valid_o && instr_ready_i, and only then are the redirect inputs used.
    assign handshake = valid_q && instr_ready_i;

`ifdef FETCH_ALIGN_CHK_EN
    logic fault_q, fault_d;
    assign fault_o = fault_q;
`else
    assign fault_o = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_hold_d  = pc_hold_q;
        pc_plus4_d = pc_plus4_q;
        req_d      = req_q;
        valid_d    = valid_q;
`ifdef FETCH_ALIGN_CHK_EN
        fault_d    = fault_q;
`endif
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                valid_d = 1'b0;
            end
            ST_FETCH: begin
                if (imem_ack_i) begin
                    instr_d    = imem_data_i;
                    pc_hold_d  = pc_q;
                    pc_plus4_d = pc_q + 32'd4;
                    state_d    = ST_HOLD;
                    req_d      = 1'b0;
                    valid_d    = 1'b1;
                end
            end
            ST_HOLD: begin
                if (handshake) begin
                    valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
                    if (next_pc[1:0] != 2'b00) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                        req_d   = 1'b0;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_FETCH;
                        req_d   = 1'b1;
                    end
`else
                    pc_d    = next_pc & ~32'h3;
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
`endif
                end
            end
            ST_FAULT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            pc_hold_q  <= 32'h0;
            pc_plus4_q <= 32'h0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_hold_q  <= pc_hold_d;
            pc_plus4_q <= pc_plus4_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
`ifdef FETCH_ALIGN_CHK_EN
            fault_q    <= fault_d;
`endif
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_hold_q;
    assign pc_plus4_o    = pc_plus4_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: redirect vector table plus hand-written
// cadence, stall, reset-abort and alignment sequences (FETCH_ALIGN_CHK_EN aware).
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  jump_sel;
    logic        branch_taken;
    logic [31:0] rs_data;
    logic        fault;
    logic [1:0]  dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    instr_fetch_unit dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_ack_i     (imem_ack),
        .imem_data_i    (imem_data),
        .instr_valid_o  (instr_valid),
        .instr_ready_i  (instr_ready),
        .instr_o        (instr),
        .pc_o           (pc),
        .pc_plus4_o     (pc_plus4),
        .jump_sel_i     (jump_sel),
        .branch_taken_i (branch_taken),
        .rs_data_i      (rs_data),
        .fault_o        (fault),
        .dbg_state_o    (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] start_pc;
        logic [31:0] instr;
        logic [1:0]  jsel;
        logic        bt;
        logic [31:0] rs;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        imem_ack     = 1'b0;
        imem_data    = 32'h0;
        instr_ready  = 1'b0;
        jump_sel     = JSEL_SEQ;
        branch_taken = 1'b0;
        rs_data      = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int i;
        i = 0;
        while (!imem_req && i < 20) begin
            @(negedge clk);
            i++;
        end
        check({name, "_req"}, {31'h0, imem_req}, 32'h1);
    endtask

    task automatic give_ack(input logic [31:0] data);
        imem_ack  = 1'b1;
        imem_data = data;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = $urandom;
    endtask

    task automatic complete(input logic [1:0] js, input logic bt, input logic [31:0] rs);
        instr_ready  = 1'b1;
        jump_sel     = js;
        branch_taken = bt;
        rs_data      = rs;
        @(negedge clk);
        instr_ready  = 1'b0;
        jump_sel     = 2'($urandom_range(0, 3));
        branch_taken = 1'($urandom_range(0, 1));
        rs_data      = $urandom;
    endtask

    initial begin
        vecs[0]  = '{32'h0000_0040, 32'h1000_0003, JSEL_SEQ, 1'b1, 32'h0,   32'h0000_0050};
        vecs[1]  = '{32'h0000_0040, 32'h1000_0003, JSEL_SEQ, 1'b0, 32'h0,   32'h0000_0044};
        vecs[2]  = '{32'h0000_0100, 32'h0800_0010, JSEL_J,   1'b0, 32'h0,   32'h0000_0040};
        vecs[3]  = '{32'h0000_0100, 32'h0800_0010, JSEL_JR,  1'b0, 32'h200, 32'h0000_0200};
        vecs[4]  = '{32'h0000_0040, 32'h1000_FFFF, JSEL_SEQ, 1'b1, 32'h0,   32'h0000_0040};
        vecs[5]  = '{32'h0000_0040, 32'h1000_0003, 2'b11,    1'b1, 32'h0,   32'h0000_0050};
        vecs[6]  = '{32'h0000_0040, 32'h1000_0003, 2'b11,    1'b0, 32'h0,   32'h0000_0044};
        vecs[7]  = '{32'h0000_0080, 32'h1000_0003, JSEL_JR,  1'b1, 32'h300, 32'h0000_0300};
        vecs[8]  = '{32'h9000_0000, 32'h0BFF_FFFF, JSEL_J,   1'b1, 32'h0,   32'h9FFF_FFFC};
        vecs[9]  = '{32'hFFFF_FFFC, 32'h0000_0000, JSEL_SEQ, 1'b0, 32'h0,   32'h0000_0000};
        vecs[10] = '{32'hFFFF_FFFC, 32'h0000_0001, JSEL_SEQ, 1'b1, 32'h0,   32'h0000_0004};

        // Reset state
        do_reset();
        check("rst_req",   {31'h0, imem_req},    32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_addr",  imem_addr,            DEFAULT_RESET_PC);
        check("rst_instr", instr,                32'h0);
        check("rst_pc",    pc,                   32'h0);
        check("rst_pc4",   pc_plus4,             32'h0);
        check("rst_fault", {31'h0, fault},       32'h0);
        check("rst_state", {30'h0, dbg_state},   {30'h0, ST_IDLE});

        // Back-to-back cadence: ack and ready held high
        imem_ack    = 1'b1;
        imem_data   = 32'h0;
        instr_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                check($sformatf("cad_req%0d", k),   {31'h0, imem_req},    32'h1);
                check($sformatf("cad_valid%0d", k), {31'h0, instr_valid}, 32'h0);
                check($sformatf("cad_addr%0d", k),  imem_addr,            32'(4 * (k / 2)));
            end else begin
                check($sformatf("cad_req%0d", k),   {31'h0, imem_req},    32'h0);
                check($sformatf("cad_valid%0d", k), {31'h0, instr_valid}, 32'h1);
                check($sformatf("cad_pc%0d", k),    pc,                   32'(4 * (k / 2)));
            end
            @(negedge clk);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b0;

        // Redirect table
        for (int v = 0; v < 11; v++) begin
            do_reset();
            wait_req($sformatf("v%0d_boot", v));
            give_ack(32'h0);
            complete(JSEL_JR, 1'b0, vecs[v].start_pc);
            check($sformatf("v%0d_start", v), imem_addr, vecs[v].start_pc);
            give_ack(vecs[v].instr);
            check($sformatf("v%0d_valid", v), {31'h0, instr_valid}, 32'h1);
            check($sformatf("v%0d_instr", v), instr,    vecs[v].instr);
            check($sformatf("v%0d_pc", v),    pc,       vecs[v].start_pc);
            check($sformatf("v%0d_pc4", v),   pc_plus4, vecs[v].start_pc + 32'd4);
            complete(vecs[v].jsel, vecs[v].bt, vecs[v].rs);
            check($sformatf("v%0d_nreq", v),  {31'h0, imem_req}, 32'h1);
            check($sformatf("v%0d_next", v),  imem_addr, vecs[v].exp_next);
        end

        // Slow memory and stalled decoder: everything stays frozen
        do_reset();
        wait_req("stall_boot");
        for (int c = 0; c < 3; c++) begin
            check($sformatf("stall_wreq%0d", c),  {31'h0, imem_req}, 32'h1);
            check($sformatf("stall_waddr%0d", c), imem_addr,         32'h0);
            @(negedge clk);
        end
        give_ack(32'hABCD_1234);
        for (int c = 0; c < 4; c++) begin
            imem_ack     = 1'b1;
            imem_data    = 32'hDEAD_0000 + 32'(c);
            jump_sel     = JSEL_JR;
            rs_data      = 32'h0000_0900;
            check($sformatf("stall_hvalid%0d", c), {31'h0, instr_valid}, 32'h1);
            check($sformatf("stall_hinstr%0d", c), instr,                32'hABCD_1234);
            check($sformatf("stall_hpc%0d", c),    pc,                   32'h0);
            check($sformatf("stall_hreq%0d", c),   {31'h0, imem_req},    32'h0);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        complete(JSEL_SEQ, 1'b0, 32'h0);
        check("stall_next", imem_addr, 32'h4);
        give_ack(32'h1111_2222);
        check("stall_instr2", instr, 32'h1111_2222);
        check("stall_pc2",    pc,    32'h4);

        // Reset mid-FETCH with a stale ack arriving in IDLE
        do_reset();
        wait_req("rabort_boot");
        give_ack(32'h0);
        complete(JSEL_SEQ, 1'b0, 32'h0);
        check("rabort_addr4", imem_addr, 32'h4);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        imem_ack  = 1'b1;
        imem_data = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_ack = 1'b0;
        check("rabort_req",   {31'h0, imem_req},    32'h1);
        check("rabort_addr",  imem_addr,            DEFAULT_RESET_PC);
        check("rabort_valid", {31'h0, instr_valid}, 32'h0);
        check("rabort_instr", instr,                32'h0);
        @(negedge clk);
        check("rabort_valid2", {31'h0, instr_valid}, 32'h0);

        // Misaligned jr target
        do_reset();
        wait_req("align_boot");
        give_ack(32'h0);
        complete(JSEL_JR, 1'b0, 32'h0000_0202);
`ifdef FETCH_ALIGN_CHK_EN
        for (int c = 0; c < 3; c++) begin
            check($sformatf("align_fault%0d", c), {31'h0, fault},       32'h1);
            check($sformatf("align_req%0d", c),   {31'h0, imem_req},    32'h0);
            check($sformatf("align_valid%0d", c), {31'h0, instr_valid}, 32'h0);
            check($sformatf("align_pc%0d", c),    imem_addr,            32'h0);
            imem_ack    = 1'b1;
            instr_ready = 1'b1;
            @(negedge clk);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        do_reset();
        check("align_rst_fault", {31'h0, fault}, 32'h0);
        @(negedge clk);
        check("align_rst_req", {31'h0, imem_req}, 32'h1);
`else
        check("align_fault", {31'h0, fault},    32'h0);
        check("align_req",   {31'h0, imem_req}, 32'h1);
        check("align_addr",  imem_addr,         32'h0000_0200);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
